// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: RV32I funct3 codes,
// FSM state enumeration and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR_SET = 3'd2,
        WR_REL = 3'd3,
        DONE   = 3'd4
    } lsu_state_e;

    // Index of the final byte of an access; only legal codes ever reach RD/WR.
    function automatic logic [1:0] lsu_last_idx(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic lsu_access_err(input logic we, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad_f3;
        logic misaligned;
        if (we) begin
            bad_f3 = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end else begin
            bad_f3 = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                       funct3 == F3_LBU || funct3 == F3_LHU);
        end
        misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                     (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of the assembled little-endian load data.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    always_comb begin
        result = 32'h0;
        case (funct3)
            F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   result = raw;
            F3_LBU:  result = {24'h0, raw[7:0]};
            F3_LHU:  result = {16'h0, raw[15:0]};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging 32-bit RV32I accesses onto a byte-wide memory,
// one byte per cycle for loads and a set/release pair of cycles per stored byte.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        mem_we
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] raw_q, raw_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] ext_data;
    logic        wr_active;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        raw_d    = raw_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    raw_d    = 32'h0;
                    cnt_d    = 2'd0;
                    err_d    = lsu_access_err(req_we, req_funct3, req_addr[1:0]);
                    if (err_d)       state_d = DONE;
                    else if (req_we) state_d = WR_SET;
                    else             state_d = RD;
                end
            end
            RD: begin
                raw_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                if (cnt_q == lsu_last_idx(funct3_q)) state_d = DONE;
                else                                 cnt_d   = cnt_q + 2'd1;
            end
            WR_SET: state_d = WR_REL;
            WR_REL: begin
                if (cnt_q == lsu_last_idx(funct3_q)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = WR_SET;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobe is a flop tracking WR_SET, so it drops for every WR_REL.
        mem_we_d = (state_d == WR_SET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            raw_q    <= 32'h0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            raw_q    <= raw_d;
            err_q    <= err_d;
            mem_we_q <= mem_we_d;
        end
    end

    lsu_load_extend u_extend (
        .raw    (raw_q),
        .funct3 (funct3_q),
        .result (ext_data)
    );

    assign wr_active  = (state_q == WR_SET) || (state_q == WR_REL);
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == DONE);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext_data : 32'h0;
    assign mem_addr   = ((state_q == RD) || wr_active) ? addr_q + {30'h0, cnt_q} : addr_q;
    assign mem_wdata  = wr_active ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign mem_we     = mem_we_q;

endmodule
